// File: rtl/serial_adder_pkg.sv
// Shared constants and state encoding for the serial adder host.
package serial_adder_pkg;

  localparam int OP_W        = 2;
  localparam int SUM_W       = 3;
  localparam int TIMEOUT_DEF = 8;
  localparam int DRAIN_DEF   = 4;

  typedef enum logic [2:0] {
    ST_DRAIN_W = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SEND_B0 = 3'd2,
    ST_SEND_B1 = 3'd3,
    ST_WAIT_EN = 3'd4,
    ST_RECV    = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/serial_adder_host.sv
// Host-side sequencer for a 2-bit serial adder: serializes operands LSB
// first, waits for the adder's start-of-result strobe and deserializes the
// 3-bit sum into a valid/ready response.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DRAIN_W  | post-reset hold-off so an unreset adder can go idle
// IDLE     | ready for a request
// SEND_B0  | drive operand bit 0 with ser_en
// SEND_B1  | drive operand bit 1
// WAIT_EN  | wait (bounded) for ser_en_o with sum bit 0
// RECV     | collect sum bits 1 and 2
// DONE     | hold response until rsp_ready
module serial_adder_host
  import serial_adder_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int DRAIN   = DRAIN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_a,
  input  logic [OP_W-1:0]  req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [SUM_W-1:0] rsp_sum,
  output logic             rsp_err,
  output logic             ser_in1,
  output logic             ser_in2,
  output logic             ser_en,
  input  logic             ser_out,
  input  logic             ser_en_o
);

  localparam int CNT_MAX = (TIMEOUT > DRAIN) ? TIMEOUT : DRAIN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e             r_state,  w_state_nx;
  logic [CNT_W-1:0]   r_cnt,    w_cnt_nx;
  logic [OP_W-1:0]    r_a,      w_a_nx;
  logic [OP_W-1:0]    r_b,      w_b_nx;
  logic [SUM_W-1:0]   r_sum,    w_sum_nx;
  logic               r_err,    w_err_nx;
  logic [1:0]         r_idx,    w_idx_nx;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic               r_ser_en;
  logic               r_ser_in1;
  logic               r_ser_in2;

  // Next-state and datapath decode.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_sum_nx   = r_sum;
    w_err_nx   = r_err;
    w_idx_nx   = r_idx;
    case (r_state)
      ST_DRAIN_W: begin
        if (r_cnt == CNT_W'(DRAIN - 1)) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_a_nx     = req_a;
          w_b_nx     = req_b;
          w_sum_nx   = '0;
          w_err_nx   = 1'b0;
          w_state_nx = ST_SEND_B0;
        end
      end
      ST_SEND_B0: w_state_nx = ST_SEND_B1;
      ST_SEND_B1: begin
        w_state_nx = ST_WAIT_EN;
        w_cnt_nx   = '0;
      end
      ST_WAIT_EN: begin
        if (ser_en_o) begin
          w_sum_nx[0] = ser_out;
          w_idx_nx    = 2'd1;
          w_state_nx  = ST_RECV;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_sum_nx   = '0;
          w_err_nx   = 1'b1;
          w_state_nx = ST_DONE;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      ST_RECV: begin
        if (r_idx == 2'd1) begin
          w_sum_nx[1] = ser_out;
          w_idx_nx    = 2'd2;
        end else begin
          w_sum_nx[2] = ser_out;
          w_err_nx    = 1'b0;
          w_state_nx  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_DRAIN_W;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // State, data and registered outputs; outputs decode from the next state
  // so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_DRAIN_W;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ser_en    <= 1'b0;
      r_ser_in1   <= 1'b0;
      r_ser_in2   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_a         <= w_a_nx;
      r_b         <= w_b_nx;
      r_sum       <= w_sum_nx;
      r_err       <= w_err_nx;
      r_idx       <= w_idx_nx;
      r_req_ready <= (w_state_nx == ST_IDLE);
      r_rsp_valid <= (w_state_nx == ST_DONE);
      r_ser_en    <= (w_state_nx == ST_SEND_B0);
      r_ser_in1   <= (w_state_nx == ST_SEND_B0) ? w_a_nx[0] :
                     (w_state_nx == ST_SEND_B1) ? w_a_nx[1] : 1'b0;
      r_ser_in2   <= (w_state_nx == ST_SEND_B0) ? w_b_nx[0] :
                     (w_state_nx == ST_SEND_B1) ? w_b_nx[1] : 1'b0;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_sum;
  assign rsp_err   = r_err;
  assign ser_en    = r_ser_en;
  assign ser_in1   = r_ser_in1;
  assign ser_in2   = r_ser_in2;

endmodule
